comparador_serial: RTL
======================

COMPARADOR_SERIAL -- requirements
Module: comparador_serial

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits; SHALL be even and >= 2.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request one comparison; sampled only in IDLE.
REQ-005 Port: A  input  WIDTH  operand A, unsigned; sampled on the accepting edge.
REQ-006 Port: B  input  WIDTH  operand B, unsigned; sampled on the accepting edge.
REQ-007 Port: busy  output  1  high while a comparison is in progress (COMPARE state).
REQ-008 Port: done  output  1  one-cycle pulse; result flags valid and newly updated.
REQ-009 Port: A_equal_B  output  1  registered result A == B.
REQ-010 Port: A_less_B  output  1  registered result A < B.
REQ-011 Port: A_greater_B  output  1  registered result A > B.

Function
REQ-012 FSM states SHALL be IDLE, COMPARE and DONE; no other states reachable.
REQ-013 IDLE with start=1 at edge E0: latch A and B into shift registers, pair counter := 0, next state COMPARE.
REQ-014 IDLE with start=0: SHALL remain IDLE, with all registers unchanged.
REQ-015 COMPARE: each cycle, present the top 2 bits of both shift registers to the 2-bit comparator, MSB pair first.
REQ-016 COMPARE, pair unequal: latch the comparator less/greater result into flags, clear A_equal_B, next state DONE (early exit).
REQ-017 COMPARE, pair equal and counter < WIDTH/2-1: shift both registers left by 2, increment counter, stay in COMPARE.
REQ-018 COMPARE, pair equal and counter = WIDTH/2-1: set A_equal_B=1, clear the other flags, next state DONE.
REQ-019 Latency: with k the 0-based index of the deciding pair, done SHALL be high in the cycle following edge E0+k+1.
REQ-020 Consequence of REQ-019: worst case is WIDTH/2 + 1 cycles from start to done; best case is 2 cycles.
REQ-021 DONE: done=1 for exactly one cycle, busy=0, next state IDLE unconditionally.
REQ-022 busy SHALL be 1 exactly in COMPARE; done SHALL be 1 exactly in DONE; the two are never high together.
REQ-023 start asserted in COMPARE or DONE SHALL be ignored; it is not queued.
REQ-024 A and B changes after E0 SHALL NOT affect the result in progress.
REQ-025 Result flags SHALL hold their value from DONE until the next DONE.
REQ-026 After the first DONE, exactly one result flag SHALL be high.
REQ-027 Back-to-back operation: start held high SHALL be accepted in the IDLE cycle following DONE.

Reset
REQ-028 reset=1 at any edge SHALL force IDLE and clear busy, done, all three flags, the counter and both shift registers to 0.
REQ-029 reset SHALL take priority over start and over any in-progress comparison; an aborted comparison never produces done.
REQ-030 The first start SHALL be accepted at the first edge where reset=0 and start=1.

Structure
REQ-031 FSM state encodings (IDLE=0, COMPARE=1, DONE=2) and the default WIDTH SHALL live in the shared package comparador_pkg.
REQ-032 The block SHALL instantiate exactly one existing 2-bit comparator sub-module, comparador, as its only compare datapath.
REQ-033 No arithmetic comparison operators SHALL be used on the operands outside the comparador instance.

Verification
REQ-034 reset, then A=0x5A, B=0x5A, start pulse -> busy for 4 cycles, done at E0+4, A_equal_B=1, other flags 0.
REQ-035 A=0xC0, B=0x40 -> early exit at k=0, done at E0+1, A_greater_B=1.
REQ-036 A=0x12, B=0x13 -> deciding pair k=3, done at E0+4, A_less_B=1; the flags hold through 10 idle cycles.
REQ-037 A=0x80, B=0x00 with start held high; A/B toggled and start pulsed again mid-run -> exactly one done, A_greater_B=1, next start accepted in the IDLE cycle after DONE.
REQ-038 Start A=0x00, B=0xFF, assert reset at E0+1 -> IDLE at the next edge, no done pulse, all outputs 0.
REQ-039 Random operands, 1000 runs, WIDTH=8 and WIDTH=2 -> flags match an integer reference model, and latency matches REQ-019.

Source files
------------

// File: rtl/comparador_pkg.sv
// Shared definitions for the serial comparator: FSM encoding, default width
// and a helper that sizes the pair counter.
package comparador_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Counter must hold 0 .. pairs-1; a single pair still needs one bit of storage.
  function automatic int cnt_width(input int pairs);
    return (pairs > 1) ? $clog2(pairs) : 1;
  endfunction

endpackage

// File: rtl/comparador.sv
// Two-bit magnitude comparator; the only place operand values are compared.
module comparador (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic       eq_o,
  output logic       lt_o,
  output logic       gt_o
);

  assign eq_o = (a_i == b_i);
  assign lt_o = (a_i <  b_i);
  assign gt_o = (a_i >  b_i);

endmodule

// File: rtl/comparador_serial.sv
// Serial unsigned comparator: walks both operands two bits per cycle, MSB pair
// first, and exits as soon as a pair differs.
//
//   state   | meaning
//   IDLE    | waiting for start; all registers hold
//   COMPARE | one operand pair examined per cycle (busy=1)
//   DONE    | flags freshly updated, done pulses for one cycle
module comparador_serial
  import comparador_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             A_equal_B,
  output logic             A_less_B,
  output logic             A_greater_B
);

  localparam int PAIRS = WIDTH / 2;
  localparam int CNT_W = cnt_width(PAIRS);
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(PAIRS - 1);

  if (((WIDTH % 2) != 0) || (WIDTH < 2)) begin : g_bad_width
    $error("comparador_serial: WIDTH must be even and >= 2");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;

  logic pair_eq, pair_lt, pair_gt;

  comparador u_comparador (
    .a_i  (a_q[WIDTH-1 -: 2]),
    .b_i  (b_q[WIDTH-1 -: 2]),
    .eq_o (pair_eq),
    .lt_o (pair_lt),
    .gt_o (pair_gt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    gt_d    = gt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          cnt_d   = '0;
          state_d = COMPARE;
        end
      end

      COMPARE: begin
        if (!pair_eq) begin
          eq_d    = 1'b0;
          lt_d    = pair_lt;
          gt_d    = pair_gt;
          state_d = DONE;
        end else if (cnt_q == LAST_PAIR) begin
          eq_d    = 1'b1;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = DONE;
        end else begin
          // Shifting brings the next lower pair into the comparator window.
          a_d   = a_q << 2;
          b_d   = b_q << 2;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q == COMPARE);
  assign done        = (state_q == DONE);
  assign A_equal_B   = eq_q;
  assign A_less_B    = lt_q;
  assign A_greater_B = gt_q;

endmodule
